// File: rtl/pir_occupancy_filter_pkg.sv
// Shared state encoding and default timing for the PIR occupancy filter.
// Defaults assume a 50 MHz clock: 1 s hold, 16-cycle debounce.
package pir_pkg;

   typedef enum logic [1:0] {
      ST_FREE     = 2'd0,
      ST_OCCUPIED = 2'd1,
      ST_HOLD     = 2'd2
   } state_e;

   localparam int DEF_SYNC_STAGES     = 2;
   localparam int DEF_DEBOUNCE_CYCLES = 16;
   localparam int DEF_HOLD_CYCLES     = 50_000_000;
   localparam int DEF_CNT_W           = 32;

   // True when value is representable as an unsigned number of the given width.
   function automatic bit fits_in(input longint value, input int width);
      return (value >> width) == 64'd0;
   endfunction

endpackage

// File: rtl/pir_occupancy_filter_if.sv
// Sensor-side and LED-side signals of the occupancy filter, bundled for the top-level port.
// The master drives the raw sensor line; the slave (the filter) drives the outputs.
interface pir_occupancy_filter_if;
   logic       pir_in;
   logic       occupied;
   logic       motion_pulse;
   logic [1:0] state;

   modport master (
      output pir_in,
      input  occupied,
      input  motion_pulse,
      input  state
   );

   modport slave (
      input  pir_in,
      output occupied,
      output motion_pulse,
      output state
   );
endinterface

// File: rtl/pir_occupancy_filter_debounce.sv
// Synchroniser chain plus level debouncer for the asynchronous PIR line.
// dout follows din only after the new level has held for DEBOUNCE_CYCLES synchronised cycles.
module pir_debounce
   import pir_pkg::*;
#(
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_stable;
   logic [CNT_W-1:0]       r_db_cnt;
   logic                   w_pir_sync;

   assign w_pir_sync = r_sync[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync   <= '0;
         r_stable <= 1'b0;
         r_db_cnt <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], din};
         // Any bounce back to the accepted level restarts the qualification window.
         if (w_pir_sync == r_stable) begin
            r_db_cnt <= '0;
         end else if (r_db_cnt == DB_LAST) begin
            r_stable <= w_pir_sync;
            r_db_cnt <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + CNT_W'(1);
         end
      end
   end

   assign dout = r_stable;

endmodule

// File: rtl/pir_occupancy_filter.sv
// PIR occupancy filter: debounced motion drives a retriggerable hold FSM feeding the LED stage.
// occupied rises SYNC_STAGES+DEBOUNCE_CYCLES+1 edges after pir_in and falls HOLD_CYCLES later.
module pir_occupancy_filter
   import pir_pkg::*;
#(
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic                    clk,
   input  logic                    rst,
   pir_occupancy_filter_if.slave   bus
);

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("pir_occupancy_filter: SYNC_STAGES must be at least 2");
   end
   if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $error("pir_occupancy_filter: DEBOUNCE_CYCLES must be at least 1");
   end
   if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("pir_occupancy_filter: HOLD_CYCLES must be at least 1");
   end
   if (!fits_in(longint'(DEBOUNCE_CYCLES), CNT_W) || !fits_in(longint'(HOLD_CYCLES), CNT_W)) begin : g_bad_width
      $error("pir_occupancy_filter: CNT_W too narrow for DEBOUNCE_CYCLES/HOLD_CYCLES");
   end

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

   state_e           r_state;
   logic [CNT_W-1:0] r_hold_cnt;
   logic             r_occupied;
   logic             r_motion_pulse;
   logic             w_pir_stable;

   pir_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_debounce (
      .clk  (clk),
      .rst  (rst),
      .din  (bus.pir_in),
      .dout (w_pir_stable)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= ST_FREE;
         r_hold_cnt     <= '0;
         r_occupied     <= 1'b0;
         r_motion_pulse <= 1'b0;
      end else begin
         r_motion_pulse <= 1'b0;
         case (r_state)
            ST_FREE: begin
               r_occupied <= w_pir_stable;
               if (w_pir_stable) begin
                  r_state        <= ST_OCCUPIED;
                  r_motion_pulse <= 1'b1;
               end
            end
            ST_OCCUPIED: begin
               r_occupied <= 1'b1;
               if (!w_pir_stable) begin
                  r_state    <= ST_HOLD;
                  r_hold_cnt <= HOLD_LAST;
               end
            end
            ST_HOLD: begin
               // Retrigger wins over expiry when both land in the same cycle.
               if (w_pir_stable) begin
                  r_state        <= ST_OCCUPIED;
                  r_motion_pulse <= 1'b1;
               end else if (r_hold_cnt == '0) begin
                  r_state    <= ST_FREE;
                  r_occupied <= 1'b0;
               end else begin
                  r_hold_cnt <= r_hold_cnt - CNT_W'(1);
               end
            end
            default: begin
               r_state    <= ST_FREE;
               r_occupied <= 1'b0;
            end
         endcase
      end
   end

   assign bus.occupied     = r_occupied;
   assign bus.motion_pulse = r_motion_pulse;
   assign bus.state        = r_state;

endmodule

// File: tb/tb_pir_occupancy_filter.sv
// Scoreboard bench: each stimulus step queues per-cycle expectations, a negedge monitor checks them.
module tb_pir_occupancy_filter;

   typedef struct {
      int         cyc;
      logic       occ;
      logic [1:0] st;
      logic       pls;
      string      tag;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   total;
   int   bad;
   exp_t sb_q[$];

   pir_occupancy_filter_if u_if ();

   pir_occupancy_filter #(
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4),
      .HOLD_CYCLES     (8),
      .CNT_W           (32)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic push(input int at, input logic occ, input logic [1:0] st, input logic pls,
                       input string tag);
      exp_t e;
      e.cyc = at;
      e.occ = occ;
      e.st  = st;
      e.pls = pls;
      e.tag = tag;
      sb_q.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t e;
      while (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
         e = sb_q.pop_front();
         if (e.cyc < cyc) begin
            chk({e.tag, "_missed"}, cyc, e.cyc);
         end else begin
            chk({e.tag, "_occ"}, u_if.occupied, e.occ);
            chk({e.tag, "_state"}, u_if.state, e.st);
            chk({e.tag, "_pulse"}, u_if.motion_pulse, e.pls);
         end
      end
   end

   task automatic wait_cyc(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && sb_q.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      if (sb_q.size() != 0) begin
         chk("drain_timeout", sb_q.size(), 0);
         sb_q.delete();
      end
   endtask

   // From FREE with a settled low input: occupied must rise exactly 7 edges later.
   task automatic rise_check(input string tag);
      int c;
      c = cyc;
      u_if.pir_in = 1'b1;
      for (int k = 1; k <= 6; k++) push(c + k, 1'b0, 2'd0, 1'b0, {tag, "_wait"});
      push(c + 7, 1'b1, 2'd1, 1'b1, {tag, "_rise"});
      push(c + 8, 1'b1, 2'd1, 1'b0, {tag, "_after"});
      drain();
   endtask

   // From OCCUPIED: HOLD after 7 edges, occupied drops exactly 15 edges after the fall.
   task automatic release_check(input string tag);
      int c;
      c = cyc;
      u_if.pir_in = 1'b0;
      for (int k = 1; k <= 6; k++)  push(c + k, 1'b1, 2'd1, 1'b0, {tag, "_occ"});
      for (int k = 7; k <= 14; k++) push(c + k, 1'b1, 2'd2, 1'b0, {tag, "_hold"});
      push(c + 15, 1'b0, 2'd0, 1'b0, {tag, "_free"});
      drain();
   endtask

   initial begin
      int c;
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      u_if.pir_in = 1'b1;

      for (int k = 1; k <= 3; k++) push(k, 1'b0, 2'd0, 1'b0, "reset");
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      rise_check("post_reset");
      release_check("release1");

      rise_check("clean");
      release_check("release2");

      // Short pulse, then a bounce whose final run of ones is accepted.
      c = cyc;
      for (int k = 1; k <= 19; k++) push(c + k, 1'b0, 2'd0, 1'b0, "glitch");
      push(c + 20, 1'b1, 2'd1, 1'b1, "bounce_rise");
      push(c + 21, 1'b1, 2'd1, 1'b0, "bounce_after");
      u_if.pir_in = 1'b1;
      wait_cyc(c + 3);
      u_if.pir_in = 1'b0;
      wait_cyc(c + 10);
      u_if.pir_in = 1'b1;
      wait_cyc(c + 12);
      u_if.pir_in = 1'b0;
      wait_cyc(c + 13);
      u_if.pir_in = 1'b1;
      drain();
      release_check("release3");

      // Retrigger lands in the same cycle the hold counter reaches zero.
      rise_check("pre_retrig");
      c = cyc;
      u_if.pir_in = 1'b0;
      for (int k = 1; k <= 6; k++)  push(c + k, 1'b1, 2'd1, 1'b0, "retrig_occ");
      for (int k = 7; k <= 14; k++) push(c + k, 1'b1, 2'd2, 1'b0, "retrig_hold");
      push(c + 15, 1'b1, 2'd1, 1'b1, "retrig_pulse");
      push(c + 16, 1'b1, 2'd1, 1'b0, "retrig_after");
      wait_cyc(c + 8);
      u_if.pir_in = 1'b1;
      drain();
      release_check("release_full");

      // Asynchronous reset in the middle of HOLD.
      rise_check("pre_arst");
      c = cyc;
      u_if.pir_in = 1'b0;
      for (int k = 1; k <= 6; k++)  push(c + k, 1'b1, 2'd1, 1'b0, "arst_occ");
      for (int k = 7; k <= 10; k++) push(c + k, 1'b1, 2'd2, 1'b0, "arst_hold");
      wait_cyc(c + 10);
      @(negedge clk);
      #2;
      chk("pre_arst_state", u_if.state, 2);
      rst = 1'b1;
      #1;
      chk("arst_occupied", u_if.occupied, 0);
      chk("arst_state", u_if.state, 0);
      chk("arst_pulse", u_if.motion_pulse, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("arst_held_state", u_if.state, 0);
      rst = 1'b0;
      drain();
      rise_check("resume");
      release_check("resume_release");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pir_occupancy_filter.md
Name: pir_occupancy_filter

Overview:
Conditioning stage directly upstream of the RGB LED driver. It takes the raw, asynchronous PIR sensor line and synchronises and debounces it. It then applies a retriggerable hold time and drives a clean "occupied" level into the LED stage: occupied=1 gives red, 0 gives green. It also emits a one-cycle motion event pulse for future logging and counting blocks.

Parameters:
SYNC_STAGES, 2, number of flip-flops in the pir_in synchroniser chain (>=2)
DEBOUNCE_CYCLES, 16, consecutive cycles a changed level must persist before it is accepted (>=1)
HOLD_CYCLES, 50_000_000, cycles occupied stays high after motion ends (>=1)
CNT_W, 32, width of the debounce and hold counters; must hold max(DEBOUNCE_CYCLES, HOLD_CYCLES)

Ports:
clk  in  1  system clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
pir_in  in  1  raw PIR sensor output, asynchronous to clk
occupied  out  1  registered occupancy level, feeds LED driver pir_in
motion_pulse  out  1  one-cycle pulse on each (re)entry into OCCUPIED
state  out  2  current FSM state, for debug

Behaviour:
- One clock, clk. Reset is asynchronous and active-high (rst).
- While rst=1, all of the following are 0: the sync chain, pir_stable, both counters, state (FREE), occupied and motion_pulse. All of them clear immediately on assertion, including mid-operation.
- Synchroniser: pir_sync is pir_in delayed through SYNC_STAGES flip-flops.
- Debounce uses a register pir_stable and a counter db_cnt:
  - If pir_sync==pir_stable, db_cnt<=0.
  - Else if db_cnt==DEBOUNCE_CYCLES-1, pir_stable<=pir_sync and db_cnt<=0.
  - Else db_cnt<=db_cnt+1.
  - Any pulse or glitch shorter than DEBOUNCE_CYCLES consecutive cycles is ignored, and the counter restarts on every bounce.
- FSM states: FREE=2'd0, OCCUPIED=2'd1, HOLD=2'd2. Encoding 2'd3 is illegal and recovers to FREE on the next edge.
  - FREE: pir_stable=1 -> OCCUPIED.
  - OCCUPIED: pir_stable=0 -> HOLD, with hold_cnt<=HOLD_CYCLES-1.
  - HOLD, pir_stable=1 -> OCCUPIED. This retrigger takes priority over expiry when both occur in the same cycle.
  - HOLD, otherwise, hold_cnt==0 -> FREE.
  - HOLD, otherwise -> stay in HOLD and decrement hold_cnt.
- Outputs:
  - occupied=1 when state is OCCUPIED or HOLD. It is driven from a register, so it is glitch-free.
  - motion_pulse=1 for exactly the first cycle in OCCUPIED after entry from FREE or HOLD. It is registered alongside state.
- Latency, rise: pir_in rising to occupied rising takes exactly SYNC_STAGES+DEBOUNCE_CYCLES+1 clk edges.
- Latency, fall: pir_in falling to occupied falling takes exactly SYNC_STAGES+DEBOUNCE_CYCLES+1+HOLD_CYCLES edges, provided there is no retrigger.
- The hold counter never wraps. It loads only on entry to HOLD and stops at 0.
- Parameter checks: an elaboration-time error is raised if SYNC_STAGES<2, DEBOUNCE_CYCLES<1, HOLD_CYCLES<1, or if either cycle count does not fit in CNT_W.

Decomposition:
- Shared package pir_pkg holds the state localparams (ST_FREE, ST_OCCUPIED, ST_HOLD) and the default timing constants.
- One sub-module, pir_debounce: synchroniser plus debounce counter. It has parameters SYNC_STAGES, DEBOUNCE_CYCLES and CNT_W, and ports clk, rst, din, dout.
- The FSM and hold counter live in pir_occupancy_filter.
- The system top instantiates pir_occupancy_filter, then the led_rgb driver.

Test Plan:
All scenarios run with SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, clk period 10 ns.
1. Reset: rst=1 for 3 cycles with pir_in=1 -> occupied=0, motion_pulse=0, state=0 throughout. After release, occupied rises 7 edges later.
2. Clean detection: pir_in 0->1 after reset -> occupied=1 exactly 7 edges later, with a single motion_pulse in that cycle and state=1.
3. Glitch rejection: pir_in high for 3 cycles, then low; also a bouncing pattern 1,1,0,1,1,1 -> occupied stays 0 and no pulse. The final 4-cycle run of 1s is accepted.
4. Release with hold: from OCCUPIED, pir_in 1->0 -> state=2 after 7 edges, occupied stays 1, then occupied falls exactly 15 edges after the pir_in fall.
5. Retrigger: in HOLD, pir_in 0->1 timed so pir_stable rises at the hold_cnt==0 cycle -> state returns to 1, a second motion_pulse fires, occupied never drops, and the hold restarts at full length on the next release.
6. Async reset mid-HOLD: assert rst between clock edges during HOLD -> occupied=0 and state=0 before the next edge. Normal operation resumes after release.
